// File: rtl/vram_write_arbiter.sv
// vram_write_arbiter: sole owner of the VideoRAM write port, merging processor writes with a rectangle-fill engine.
// Define VRAM_CLEAR_ON_RESET_EN to make the engine clear the whole screen to black after every reset.
module vram_write_arbiter #(
  parameter int ROWS = 60,
  parameter int COLS = 80
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iCpuWriteEnable,
  input  logic [5:0]  iCpuRow,
  input  logic [6:0]  iCpuCol,
  input  logic [2:0]  iCpuRGB,
  input  logic        iFillStart,
  input  logic [5:0]  iFillRow0,
  input  logic [6:0]  iFillCol0,
  input  logic [5:0]  iFillRow1,
  input  logic [6:0]  iFillCol1,
  input  logic [2:0]  iFillRGB,
  output logic        oWriteEnable,
  output logic [12:0] oWriteAddress,
  output logic [2:0]  oWriteData,
  output logic        oFillBusy,
  output logic        oFillDone,
  output logic        oFillError
);

  localparam logic [5:0] RowLast = 6'(ROWS - 1);
  localparam logic [6:0] ColLast = 7'(COLS - 1);

  typedef enum logic [1:0] {Idle, Fill, Done} state_t;

`ifdef VRAM_CLEAR_ON_RESET_EN
  localparam state_t ResetState = Fill;
`else
  localparam state_t ResetState = Idle;
`endif

  state_t state, stateNext;

  logic [5:0]  row0, row1, rowCnt;
  logic [6:0]  col0, col1, colCnt;
  logic [2:0]  fillRGB;

  logic        startValid, startAccept, startReject, fillGrant, lastCell;

  logic        wrEn_p0;
  logic [12:0] wrAddr_p0;
  logic [2:0]  wrData_p0;
  logic        wrEn_p1;
  logic [12:0] wrAddr_p1;
  logic [2:0]  wrData_p1;
  logic        fillError_p1;

  assign startValid  = (iFillRow0 <= iFillRow1) && (iFillCol0 <= iFillCol1) &&
                       (iFillRow1 <= RowLast)   && (iFillCol1 <= ColLast);
  assign startAccept = (state == Idle) && iFillStart && startValid;
  assign startReject = (state == Idle) && iFillStart && !startValid;
  // The processor always wins; the engine only moves on cycles it leaves free.
  assign fillGrant   = (state == Fill) && !iCpuWriteEnable;
  assign lastCell    = (rowCnt == row1) && (colCnt == col1);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state <= ResetState;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      Idle:    if (startAccept)          stateNext = Fill;
      Fill:    if (fillGrant && lastCell) stateNext = Done;
      Done:                               stateNext = Idle;
      default:                            stateNext = Idle;
    endcase
  end

  always_comb begin
    oFillBusy = (state != Idle);
    oFillDone = (state == Done);
    wrEn_p0   = 1'b0;
    wrAddr_p0 = '0;
    wrData_p0 = '0;
    if (iCpuWriteEnable) begin
      wrEn_p0   = 1'b1;
      wrAddr_p0 = {iCpuRow, iCpuCol};
      wrData_p0 = iCpuRGB;
    end else if (fillGrant) begin
      wrEn_p0   = 1'b1;
      wrAddr_p0 = {rowCnt, colCnt};
      wrData_p0 = fillRGB;
    end
  end

  // Rectangle bounds are sampled only on an accepted start.
`ifdef VRAM_CLEAR_ON_RESET_EN
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      row0    <= '0;
      col0    <= '0;
      row1    <= RowLast;
      col1    <= ColLast;
      fillRGB <= '0;
    end else if (startAccept) begin
      row0    <= iFillRow0;
      col0    <= iFillCol0;
      row1    <= iFillRow1;
      col1    <= iFillCol1;
      fillRGB <= iFillRGB;
    end
  end
`else
  always_ff @(posedge Clock) begin
    if (startAccept) begin
      row0    <= iFillRow0;
      col0    <= iFillCol0;
      row1    <= iFillRow1;
      col1    <= iFillCol1;
      fillRGB <= iFillRGB;
    end
  end
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      rowCnt <= '0;
      colCnt <= '0;
    end else if (startAccept) begin
      rowCnt <= iFillRow0;
      colCnt <= iFillCol0;
    end else if (fillGrant && !lastCell) begin
      if (colCnt == col1) begin
        colCnt <= col0;
        rowCnt <= rowCnt + 6'd1;
      end else begin
        colCnt <= colCnt + 7'd1;
      end
    end
  end

  // p0 -> p1: registered write port and error pulse
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wrEn_p1      <= 1'b0;
      wrAddr_p1    <= '0;
      wrData_p1    <= '0;
      fillError_p1 <= 1'b0;
    end else begin
      wrEn_p1      <= wrEn_p0;
      wrAddr_p1    <= wrAddr_p0;
      wrData_p1    <= wrData_p0;
      fillError_p1 <= startReject;
    end
  end

  assign oWriteEnable  = wrEn_p1;
  assign oWriteAddress = wrAddr_p1;
  assign oWriteData    = wrData_p1;
  assign oFillError    = fillError_p1;

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Directed bench for vram_write_arbiter: expected port writes are queued when driven and checked as they appear.
module tb_vram_write_arbiter;

  logic        Clock;
  logic        Reset;
  logic        iCpuWriteEnable;
  logic [5:0]  iCpuRow;
  logic [6:0]  iCpuCol;
  logic [2:0]  iCpuRGB;
  logic        iFillStart;
  logic [5:0]  iFillRow0;
  logic [6:0]  iFillCol0;
  logic [5:0]  iFillRow1;
  logic [6:0]  iFillCol1;
  logic [2:0]  iFillRGB;
  logic        oWriteEnable;
  logic [12:0] oWriteAddress;
  logic [2:0]  oWriteData;
  logic        oFillBusy;
  logic        oFillDone;
  logic        oFillError;

`ifdef VRAM_CLEAR_ON_RESET_EN
  localparam logic RstBusy = 1'b1;
`else
  localparam logic RstBusy = 1'b0;
`endif

  vram_write_arbiter #(.ROWS(60), .COLS(80)) dut (
    .Clock(Clock), .Reset(Reset),
    .iCpuWriteEnable(iCpuWriteEnable), .iCpuRow(iCpuRow), .iCpuCol(iCpuCol), .iCpuRGB(iCpuRGB),
    .iFillStart(iFillStart), .iFillRow0(iFillRow0), .iFillCol0(iFillCol0),
    .iFillRow1(iFillRow1), .iFillCol1(iFillCol1), .iFillRGB(iFillRGB),
    .oWriteEnable(oWriteEnable), .oWriteAddress(oWriteAddress), .oWriteData(oWriteData),
    .oFillBusy(oFillBusy), .oFillDone(oFillDone), .oFillError(oFillError)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    int          due;
    logic [12:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t sb[$];
  int  cyc   = 0;
  int  total = 0;
  int  bad   = 0;

  function automatic logic [12:0] adr(int r, int c);
    return {6'(r), 7'(c)};
  endfunction

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic pushWr(int due, logic [12:0] a, logic [2:0] d);
    wr_t e;
    e.due  = due;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic pushRect(int r0, int c0, int r1, int c1, logic [2:0] d, int due);
    int t;
    t = due;
    for (int r = r0; r <= r1; r++)
      for (int c = c0; c <= c1; c++) begin
        pushWr(t, adr(r, c), d);
        t++;
      end
  endtask

  task automatic checkPort();
    logic expWr;
    wr_t  e;
    expWr = (sb.size() > 0) && (sb[0].due == cyc);
    chk("wr_en", 16'(oWriteEnable), 16'(expWr));
    if (expWr) begin
      e = sb.pop_front();
      chk("wr_addr", 16'(oWriteAddress), 16'(e.addr));
      chk("wr_data", 16'(oWriteData), 16'(e.data));
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
    cyc++;
    checkPort();
  endtask

  task automatic flags(logic b, logic d, logic e);
    chk("busy", 16'(oFillBusy), 16'(b));
    chk("done", 16'(oFillDone), 16'(d));
    chk("error", 16'(oFillError), 16'(e));
  endtask

  task automatic startFill(int r0, int c0, int r1, int c1, logic [2:0] d);
    iFillStart = 1'b1;
    iFillRow0  = 6'(r0);
    iFillCol0  = 7'(c0);
    iFillRow1  = 6'(r1);
    iFillCol1  = 7'(c1);
    iFillRGB   = d;
  endtask

  task automatic cpuWrite(logic en, int r, int c, logic [2:0] d);
    iCpuWriteEnable = en;
    iCpuRow         = 6'(r);
    iCpuCol         = 7'(c);
    iCpuRGB         = d;
  endtask

`ifdef VRAM_CLEAR_ON_RESET_EN
  task automatic clearRun();
    pushRect(0, 0, 59, 79, 3'b000, cyc + 1);
    repeat (4799) tick();
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b1, 1'b0);
    tick();
    flags(1'b0, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    Reset = 1'b1;
    cpuWrite(1'b0, 0, 0, 3'b000);
    startFill(0, 0, 0, 0, 3'b000);
    iFillStart = 1'b0;
    tick();
    tick();
    chk("rst_addr", 16'(oWriteAddress), 16'h0000);
    chk("rst_data", 16'(oWriteData), 16'h0000);
    flags(RstBusy, 1'b0, 1'b0);
    Reset = 1'b0;
`ifdef VRAM_CLEAR_ON_RESET_EN
    clearRun();
`endif

    // processor write, one-cycle latency
    cpuWrite(1'b1, 5, 10, 3'b101);
    pushWr(cyc + 1, 13'h028A, 3'b101);
    tick();
    cpuWrite(1'b0, 0, 0, 3'b000);
    flags(1'b0, 1'b0, 1'b0);
    tick();
    tick();

    // plain 2x2 fill; inputs scrambled after the start
    startFill(2, 3, 3, 4, 3'b010);
    pushRect(2, 3, 3, 4, 3'b010, cyc + 2);
    tick();
    flags(1'b1, 1'b0, 1'b0);
    startFill(40, 1, 50, 70, 3'b111);
    iFillStart = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      flags(1'b1, (i == 4), 1'b0);
    end
    tick();
    flags(1'b0, 1'b0, 1'b0);

    // same fill with a processor write on the second fill cycle
    startFill(2, 3, 3, 4, 3'b010);
    pushWr(cyc + 2, adr(2, 3), 3'b010);
    pushWr(cyc + 3, 13'h0000, 3'b111);
    pushWr(cyc + 4, adr(2, 4), 3'b010);
    pushWr(cyc + 5, adr(3, 3), 3'b010);
    pushWr(cyc + 6, adr(3, 4), 3'b010);
    tick();
    iFillStart = 1'b0;
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b0, 1'b0);
    cpuWrite(1'b1, 0, 0, 3'b111);
    tick();
    cpuWrite(1'b0, 0, 0, 3'b000);
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b1, 1'b0);
    tick();
    flags(1'b0, 1'b0, 1'b0);

    // rejected starts
    startFill(7, 0, 3, 0, 3'b001);
    tick();
    flags(1'b0, 1'b0, 1'b1);
    iFillStart = 1'b0;
    tick();
    flags(1'b0, 1'b0, 1'b0);
    startFill(0, 0, 3, 80, 3'b001);
    tick();
    flags(1'b0, 1'b0, 1'b1);
    iFillStart = 1'b0;
    tick();
    flags(1'b0, 1'b0, 1'b0);

    // single cell at the bottom-right corner
    startFill(59, 79, 59, 79, 3'b011);
    pushWr(cyc + 2, adr(59, 79), 3'b011);
    tick();
    iFillStart = 1'b0;
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b1, 1'b0);
    tick();
    flags(1'b0, 1'b0, 1'b0);

    // start coinciding with two back-to-back processor writes
    startFill(10, 10, 10, 10, 3'b001);
    cpuWrite(1'b1, 1, 1, 3'b110);
    pushWr(cyc + 1, adr(1, 1), 3'b110);
    pushWr(cyc + 2, adr(1, 2), 3'b100);
    pushWr(cyc + 3, adr(10, 10), 3'b001);
    tick();
    iFillStart = 1'b0;
    cpuWrite(1'b1, 1, 2, 3'b100);
    flags(1'b1, 1'b0, 1'b0);
    tick();
    cpuWrite(1'b0, 0, 0, 3'b000);
    flags(1'b1, 1'b0, 1'b0);
    tick();
    flags(1'b1, 1'b1, 1'b0);
    tick();
    flags(1'b0, 1'b0, 1'b0);

    // start pulse during FILL is ignored
    startFill(0, 0, 0, 5, 3'b111);
    pushRect(0, 0, 0, 5, 3'b111, cyc + 2);
    tick();
    iFillStart = 1'b0;
    tick();
    startFill(1, 1, 1, 1, 3'b000);
    tick();
    iFillStart = 1'b0;
    flags(1'b1, 1'b0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      tick();
      flags(1'b1, (i == 6), 1'b0);
    end
    tick();
    flags(1'b0, 1'b0, 1'b0);

    // reset mid-fill aborts at once
    startFill(0, 0, 3, 79, 3'b101);
    pushRect(0, 0, 3, 79, 3'b101, cyc + 2);
    tick();
    iFillStart = 1'b0;
    tick();
    tick();
    #2;
    Reset = 1'b1;
    #1;
    chk("rst_mid_wr_en", 16'(oWriteEnable), 16'h0000);
    chk("rst_mid_busy", 16'(oFillBusy), 16'(RstBusy));
    sb.delete();
    tick();
    flags(RstBusy, 1'b0, 1'b0);
    tick();
    Reset = 1'b0;
`ifdef VRAM_CLEAR_ON_RESET_EN
    clearRun();
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      flags(1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Owner of the single VideoRAM write port (80x60 cells, 3-bit RGB, address {row[5:0], col[6:0]}). Merges processor STC writes with a hardware rectangle-fill engine, so the program can clear or paint regions without looping per cell. Processor writes always win. The fill engine advances only on cycles the processor leaves free.

## Interface
Parameters:
- ROWS, 60, rows in VideoRAM
- COLS, 80, columns in VideoRAM

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high
- iCpuWriteEnable  in  1  processor STC write request, single cycle, never stalled
- iCpuRow  in  6  processor target row
- iCpuCol  in  7  processor target column
- iCpuRGB  in  3  processor colour
- iFillStart  in  1  start pulse for the fill engine
- iFillRow0  in  6  rectangle top row, inclusive
- iFillCol0  in  7  rectangle left column, inclusive
- iFillRow1  in  6  rectangle bottom row, inclusive
- iFillCol1  in  7  rectangle right column, inclusive
- iFillRGB  in  3  fill colour
- oWriteEnable  out  1  VideoRAM write enable, registered
- oWriteAddress  out  13  {row, col}, registered
- oWriteData  out  3  RGB, registered
- oFillBusy  out  1  engine active
- oFillDone  out  1  one-cycle pulse when the last cell has been issued
- oFillError  out  1  one-cycle pulse when a start is rejected

## Operation
- All outputs reset to 0. The FSM resets to IDLE; row/col counters reset to 0.
- FSM states:
  - IDLE: sampling iFillStart.
    - Valid start: latch the rectangle bounds and colour, load the counters with (Row0, Col0), go to FILL.
    - Invalid start (Row0>Row1, Col0>Col1, Row1>=ROWS or Col1>=COLS): pulse oFillError, stay in IDLE.
  - FILL: issue one cell per granted cycle.
    - Column increments. At Col1 it wraps to Col0 and row increments.
    - After cell (Row1, Col1) is issued, go to DONE.
  - DONE: pulse oFillDone for one cycle, return to IDLE.
- Arbitration per cycle: iCpuWriteEnable=1 grants the processor and freezes the engine counters. Otherwise FILL grants the engine. Otherwise there is no write.
- iFillStart in FILL or DONE is ignored: no error, no restart.
- Inputs iFillRow*/Col*/RGB are sampled only on an accepted start and may change afterward.
- oFillBusy = 1 in FILL and DONE.
- Processor and engine writing the same cell: the later-issued write is the one that lands. No coherency is provided.
- Reset mid-fill aborts immediately. No further writes, no oFillDone.

## Timing
- Processor request at cycle N appears on the write port at N+1 (one-cycle latency).
- Valid start at cycle N (IDLE): first fill write at N+1, provided the processor is idle at N+1.
- Fill duration = (Row1-Row0+1)*(Col1-Col0+1) + number of processor-granted cycles during FILL.
- oFillDone follows the cycle after the last fill write issues. The next start is accepted the cycle after oFillDone.
- iFillStart and iCpuWriteEnable in the same cycle: start is accepted and the processor write is issued. The engine's first cell slips by one cycle for each consecutive processor write.
- Single-cell rectangle (Row0=Row1, Col0=Col1): exactly one fill write, then DONE.

## Configuration
- VRAM_CLEAR_ON_RESET_EN defined:
  - After Reset deasserts, the engine self-starts a full-screen fill, (0,0)-(ROWS-1,COLS-1), colour 3'b000.
  - oFillBusy is high throughout and oFillDone pulses at completion.
  - iFillStart is ignored until this fill finishes.
  - Processor writes still take priority.
- Not defined: the FSM sits in IDLE after reset and VideoRAM contents are untouched.

## Test plan
- Processor write: iCpuWriteEnable=1, row 5, col 10, RGB 3'b101 at cycle N. At N+1: oWriteEnable=1, oWriteAddress=13'h028A, oWriteData=3'b101. Nothing else follows.
- Fill (2,3)-(3,4), RGB 3'b010, no processor traffic:
  - Four writes on consecutive cycles to (2,3), (2,4), (3,3), (3,4).
  - oFillDone pulses the next cycle.
  - oFillBusy is high for 5 cycles.
- Same fill with the processor writing (0,0) on the 2nd fill cycle: processor write is issued that cycle, fill resumes at (2,4), and total busy time is 6 cycles.
- Invalid starts, one at a time: Row0=7, Row1=3; then Col1=80. Each gives a one-cycle oFillError pulse, oFillBusy stays 0, and no writes occur.
- Start pulse during FILL is ignored. Reset asserted mid-fill drops oWriteEnable and oFillBusy to 0 at once, and no oFillDone occurs.
- With VRAM_CLEAR_ON_RESET_EN: after reset release, 4800 writes of 3'b000 cover (0,0)..(59,79), then oFillDone pulses.
